// File: rtl/seq_wide_compare_ctrl.sv
// Wide-operand comparator: walks NWORDS words of W bits through one comparator slice,
// most-significant word first, and stops at the first word that differs.
module seq_wide_compare_ctrl #(
    parameter int W      = 6,
    parameter int NWORDS = 4,
    parameter int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [W-1:0]    a_word,
    input  logic [W-1:0]    b_word,
    output logic [IDXW-1:0] word_idx,
    output logic            busy,
    output logic            done,
    output logic            lt,
    output logic            ltu,
    output logic            eq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NWORDS - 1);

    state_t          state_q;
    logic [IDXW-1:0] word_idx_q;
    logic            busy_q;
    logic            done_q;
    logic            lt_q;
    logic            ltu_q;
    logic            eq_q;

    // Single shared comparator slice.
    logic word_eq;
    logic word_ltu;
    logic word_lts;
    logic at_top;
    logic at_bottom;
    logic lt_d;
    logic ltu_d;
    logic eq_d;

    assign word_eq   = (a_word == b_word);
    assign word_ltu  = (a_word < b_word);
    assign word_lts  = ($signed(a_word) < $signed(b_word));
    assign at_top    = (word_idx_q == TOP_IDX);
    assign at_bottom = (word_idx_q == '0);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lt_d  = 1'b0;
        ltu_d = 1'b0;
        eq_d  = 1'b0;
        if (!word_eq) begin
            ltu_d = word_ltu;
            // Only the top word carries the operand sign; lower words are magnitude bits.
            lt_d  = at_top ? word_lts : word_ltu;
        end else if (at_bottom) begin
            eq_d  = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            word_idx_q <= TOP_IDX;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lt_q       <= 1'b0;
            ltu_q      <= 1'b0;
            eq_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    word_idx_q <= TOP_IDX;
                    done_q     <= 1'b0;
                    if (start) begin
                        state_q <= S_CMP;
                        busy_q  <= 1'b1;
                    end
                end
                S_CMP: begin
                    if (abort) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        word_idx_q <= TOP_IDX;
                    end else if (!word_eq || at_bottom) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        lt_q    <= lt_d;
                        ltu_q   <= ltu_d;
                        eq_q    <= eq_d;
                    end else begin
                        word_idx_q <= word_idx_q - IDXW'(1);
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    done_q     <= 1'b0;
                    word_idx_q <= TOP_IDX;
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    word_idx_q <= TOP_IDX;
                end
            endcase
        end
    end

    assign word_idx = word_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign lt       = lt_q;
    assign ltu      = ltu_q;
    assign eq       = eq_q;

endmodule

// File: tb/tb_seq_wide_compare_ctrl.sv
// Scoreboard bench for seq_wide_compare_ctrl: directed operand pairs with hand-computed
// results; a monitor pops expectations on each done pulse and checks results and latency.
module tb_seq_wide_compare_ctrl;

    localparam int W      = 6;
    localparam int NWORDS = 4;
    localparam int IDXW   = 2;
    localparam int OPW    = W * NWORDS;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [W-1:0]    a_word;
    logic [W-1:0]    b_word;
    logic [IDXW-1:0] word_idx;
    logic            busy;
    logic            done;
    logic            lt;
    logic            ltu;
    logic            eq;

    logic [OPW-1:0]  a_op = '0;
    logic [OPW-1:0]  b_op = '0;

    typedef struct {
        logic lt;
        logic ltu;
        logic eq;
        int   k;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    seq_wide_compare_ctrl #(.W(W), .NWORDS(NWORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .a_word   (a_word),
        .b_word   (b_word),
        .word_idx (word_idx),
        .busy     (busy),
        .done     (done),
        .lt       (lt),
        .ltu      (ltu),
        .eq       (eq)
    );

    always #5 clk = ~clk;

    // Operand store: combinational word read.
    always_comb begin
        a_word = a_op[int'(word_idx) * W +: W];
        b_word = b_op[int'(word_idx) * W +: W];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: latency measured from the first cycle busy is seen high.
    initial begin : monitor
        int   ncyc;
        int   s_cyc;
        logic prev_busy;
        exp_t e;
        ncyc = 0;
        s_cyc = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (busy && !prev_busy) s_cyc = ncyc;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("lt",      32'(lt),  32'(e.lt));
                    check("ltu",     32'(ltu), 32'(e.ltu));
                    check("eq",      32'(eq),  32'(e.eq));
                    check("latency", 32'(ncyc - s_cyc), 32'(e.k));
                end
            end
            prev_busy = busy;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_lt"},       32'(lt),       32'd0);
        check({tag, "_ltu"},      32'(ltu),      32'd0);
        check({tag, "_eq"},       32'(eq),       32'd0);
        check({tag, "_word_idx"}, 32'(word_idx), 32'd3);
    endtask

    // One comparison; called with inputs changing right after a falling edge.
    task automatic run_cmp(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                           input logic elt, input logic eltu, input logic eeq,
                           input int k, input bit abort_with_start);
        exp_t e;
        e.lt = elt; e.ltu = eltu; e.eq = eeq; e.k = k;
        sb.push_back(e);
        a_op  = a;
        b_op  = b;
        start = 1'b1;
        abort = abort_with_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int j = 0; j < k; j++) begin
            if (j > 0) @(negedge clk);
            check("busy_cmp", 32'(busy),     32'd1);
            check("word_idx", 32'(word_idx), 32'(3 - j));
        end
        @(negedge clk);
        check("busy_done_cycle", 32'(busy), 32'd0);
        @(negedge clk);
        check("idle_word_idx", 32'(word_idx), 32'd3);
        check("idle_busy",     32'(busy),     32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All equal: full scan, eq.
        run_cmp(24'h123456, 24'h123456, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        // Negative top word vs positive: resolves on the first word.
        run_cmp({6'h20, 6'h00, 6'h00, 6'h00}, 24'h000001, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        // Differ only in the bottom word.
        run_cmp(24'h000001, 24'h000002, 1'b1, 1'b1, 1'b0, 4, 1'b0);
        // Bottom word 3F vs 01 is unsigned: a > b.
        run_cmp({6'h2A, 6'h15, 6'h00, 6'h3F}, {6'h2A, 6'h15, 6'h00, 6'h01},
                1'b0, 1'b0, 1'b0, 4, 1'b0);
        // Top word 31 vs -32: signed greater, unsigned less.
        run_cmp({6'h1F, 6'h00, 6'h00, 6'h00}, {6'h20, 6'h00, 6'h00, 6'h00},
                1'b0, 1'b1, 1'b0, 1, 1'b0);
        // Second word differs with its MSB set in b; start with abort in IDLE: start wins.
        run_cmp({6'h05, 6'h10, 6'h3F, 6'h00}, {6'h05, 6'h30, 6'h00, 6'h00},
                1'b1, 1'b1, 1'b0, 2, 1'b1);

        // Abort at edge 2: no done, results retained (1,1,0).
        a_op  = '0;
        b_op  = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_word_idx", 32'(word_idx), 32'd3);
        check("abort_lt",       32'(lt),       32'd1);
        check("abort_ltu",      32'(ltu),      32'd1);
        check("abort_eq",       32'(eq),       32'd0);
        repeat (5) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // Reset in the middle of a comparison.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);

        // start held through CMP and DONE, dropped in IDLE: exactly one done.
        sb.push_back('{lt: 1'b1, ltu: 1'b1, eq: 1'b0, k: 1});
        a_op  = {6'h00, 6'h3F, 6'h3F, 6'h3F};
        b_op  = {6'h01, 6'h00, 6'h00, 6'h00};
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("held_start_idle_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("held_start_no_retrigger", 32'(busy), 32'd0);

        // start held high: back-to-back comparisons, first result holds through second CMP.
        sb.push_back('{lt: 1'b0, ltu: 1'b0, eq: 1'b0, k: 1});
        sb.push_back('{lt: 1'b0, ltu: 1'b0, eq: 1'b1, k: 4});
        a_op  = {6'h21, 6'h00, 6'h00, 6'h00};
        b_op  = {6'h20, 6'h00, 6'h00, 6'h00};
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("b2b_idle_gap_busy", 32'(busy), 32'd0);
        a_op = {4{6'h15}};
        b_op = {4{6'h15}};
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_busy", 32'(busy), 32'd1);
        check("b2b_hold_lt",     32'(lt),   32'd0);
        check("b2b_hold_ltu",    32'(ltu),  32'd0);
        check("b2b_hold_eq",     32'(eq),   32'd0);
        repeat (6) @(negedge clk);
        check("b2b_final_eq", 32'(eq), 32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
